// File: rtl/uart_fifo_hd.sv
// Buffered UART with TX/RX FIFOs, per-direction baud timing, sticky error flags
// and a half-duplex mode that drives a single shared wire and ignores its own echo.

module uart_fifo_hd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign dout    = mem[rd_ptr];
    // The pop is resolved first, so a push into a full FIFO succeeds alongside a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      level <= level + LW'(1);
            else if (do_pop && !do_push) level <= level - LW'(1);
        end
    end
endmodule

module uart_fifo_hd #(
    parameter int    DATA_BITS  = 8,
    parameter string PARITY_BIT = "even",
    parameter int    STOP_BITS  = 2,
    parameter int    FIFO_DEPTH = 16,
    parameter int    DIV_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DIV_WIDTH-1:0]              clk_div,
    input  logic                              half_duplex,
    input  logic [DATA_BITS-1:0]              tx_data,
    input  logic                              tx_wr_en,
    output logic                              tx_full,
    output logic                              tx_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   tx_level,
    output logic [DATA_BITS-1:0]              rx_data,
    input  logic                              rx_rd_en,
    output logic                              rx_full,
    output logic                              rx_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_level,
    output logic                              err_parity,
    output logic                              err_frame,
    output logic                              err_overrun,
    output logic                              err_tx_ovf,
    input  logic                              err_clr,
    output logic                              busy,
    output logic                              tx,
    output logic                              tx_oe,
    input  logic                              rx
);
    localparam bit HAS_PAR = (PARITY_BIT != "none");
    localparam bit ODD_PAR = (PARITY_BIT == "odd");
    localparam int GW      = DIV_WIDTH + 4;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    tx_state_t tx_state, tx_next;
    rx_state_t rx_state, rx_next;

    logic [DATA_BITS-1:0] tx_fifo_dout;
    logic                 tx_pop;
    logic                 rx_push_q;
    logic                 hd_reg;
    logic                 hd_nxt;
    logic                 both_idle;
    logic [GW-1:0]        guard;

    uart_fifo_hd_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_wr_en), .pop(tx_pop), .din(tx_data),
        .dout(tx_fifo_dout), .full(tx_full), .empty(tx_empty), .level(tx_level)
    );

    logic [DATA_BITS-1:0] rx_shift;

    uart_fifo_hd_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push_q), .pop(rx_rd_en), .din(rx_shift),
        .dout(rx_data), .full(rx_full), .empty(rx_empty), .level(rx_level)
    );

    assign both_idle = (tx_state == TX_IDLE) && (rx_state == RX_IDLE);
    assign hd_nxt    = both_idle ? half_duplex : hd_reg;
    assign busy      = (tx_state != TX_IDLE) || !tx_empty;

    // ---------------- transmitter ----------------
    logic [DIV_WIDTH-1:0] tx_div, tx_cnt;
    logic [3:0]           tx_tick_cnt, tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_tick, tx_bit_end, tx_can_start;

    assign tx_tick      = (tx_cnt == '0);
    assign tx_bit_end   = tx_tick && (tx_tick_cnt == 4'd15);
    assign tx_can_start = !tx_empty && !(hd_reg && (rx_state != RX_IDLE));

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            TX_IDLE:   if (tx_can_start) begin tx_next = TX_START; tx_pop = 1'b1; end
            TX_START:  if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA:   if (tx_bit_end && tx_bit == 4'(DATA_BITS-1))
                           tx_next = HAS_PAR ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
            TX_STOP:   if (tx_bit_end && tx_bit == 4'(STOP_BITS-1)) begin
                           if (tx_can_start) begin tx_next = TX_START; tx_pop = 1'b1; end
                           else tx_next = TX_IDLE;
                       end
            default:   tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (tx_state)
            TX_START:  tx = 1'b0;
            TX_DATA:   tx = tx_shift[0];
            TX_PARITY: tx = tx_par;
            default:   tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    // The divisor is captured per frame so clk_div changes never stretch a frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_div      <= '0;
            tx_cnt      <= '0;
            tx_tick_cnt <= '0;
            tx_bit      <= '0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
        end else if (tx_pop) begin
            tx_div      <= clk_div;
            tx_cnt      <= clk_div;
            tx_tick_cnt <= '0;
            tx_bit      <= '0;
            tx_shift    <= tx_fifo_dout;
            tx_par      <= (^tx_fifo_dout) ^ ODD_PAR;
        end else if (tx_state != TX_IDLE) begin
            if (tx_tick) begin
                tx_cnt      <= tx_div;
                tx_tick_cnt <= tx_tick_cnt + 4'd1;
            end else begin
                tx_cnt <= tx_cnt - DIV_WIDTH'(1);
            end
            if (tx_bit_end) begin
                if (tx_state == TX_DATA) tx_shift <= tx_shift >> 1;
                tx_bit <= (tx_next != tx_state) ? 4'd0 : tx_bit + 4'd1;
            end
        end
    end

    // ---------------- receiver ----------------
    logic                 rx_s1, rx_s2, rx_prev;
    logic [DIV_WIDTH-1:0] rx_div, rx_cnt;
    logic [3:0]           rx_tick_cnt, rx_bit;
    logic                 rx_par, rx_stop_bad;
    logic                 rx_tick, rx_sample, rx_bit_end, rx_hold, rx_start, rx_done;
    logic                 frame_bad, par_bad;
    logic                 frame_evt_q, par_evt_q;

    assign rx_tick    = (rx_cnt == '0);
    assign rx_sample  = rx_tick && (rx_tick_cnt == 4'd7);
    assign rx_bit_end = rx_tick && (rx_tick_cnt == 4'd15);
    // Echo and line-turnaround suppression on the shared wire.
    assign rx_hold    = hd_reg && ((tx_state != TX_IDLE) || (guard != '0));
    assign frame_bad  = rx_stop_bad || !rx_s2;
    assign par_bad    = HAS_PAR && (rx_par != ((^rx_shift) ^ ODD_PAR));

    always_comb begin
        rx_next  = rx_state;
        rx_start = 1'b0;
        rx_done  = 1'b0;
        if (rx_hold) begin
            rx_next = RX_IDLE;
        end else begin
            case (rx_state)
                RX_IDLE:   if (rx_prev && !rx_s2) begin rx_next = RX_START; rx_start = 1'b1; end
                RX_START:  if (rx_sample && rx_s2) rx_next = RX_IDLE;
                           else if (rx_bit_end) rx_next = RX_DATA;
                RX_DATA:   if (rx_bit_end && rx_bit == 4'(DATA_BITS-1))
                               rx_next = HAS_PAR ? RX_PARITY : RX_STOP;
                RX_PARITY: if (rx_bit_end) rx_next = RX_STOP;
                RX_STOP:   if (rx_sample && rx_bit == 4'(STOP_BITS-1)) begin
                               rx_next = RX_IDLE;
                               rx_done = 1'b1;
                           end
                default:   rx_next = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            rx_prev     <= 1'b1;
            rx_div      <= '0;
            rx_cnt      <= '0;
            rx_tick_cnt <= '0;
            rx_bit      <= '0;
            rx_shift    <= '0;
            rx_par      <= 1'b0;
            rx_stop_bad <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (rx_start) begin
                rx_div      <= clk_div;
                rx_cnt      <= clk_div;
                rx_tick_cnt <= '0;
                rx_bit      <= '0;
                rx_stop_bad <= 1'b0;
            end else if (rx_state != RX_IDLE) begin
                if (rx_tick) begin
                    rx_cnt      <= rx_div;
                    rx_tick_cnt <= rx_tick_cnt + 4'd1;
                end else begin
                    rx_cnt <= rx_cnt - DIV_WIDTH'(1);
                end
                if (rx_sample) begin
                    case (rx_state)
                        RX_DATA:   rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                        RX_PARITY: rx_par   <= rx_s2;
                        RX_STOP:   if (!rx_s2) rx_stop_bad <= 1'b1;
                        default:   ;
                    endcase
                end
                if (rx_bit_end) rx_bit <= (rx_next != rx_state) ? 4'd0 : rx_bit + 4'd1;
            end
        end
    end

    // Frame outcome is registered; the good byte enters the FIFO one cycle after the last stop sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_push_q   <= 1'b0;
            frame_evt_q <= 1'b0;
            par_evt_q   <= 1'b0;
        end else begin
            rx_push_q   <= rx_done && !frame_bad && !par_bad;
            frame_evt_q <= rx_done && frame_bad;
            par_evt_q   <= rx_done && !frame_bad && par_bad;
        end
    end

    // ---------------- mode, pad enable, guard, errors ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hd_reg <= 1'b0;
            tx_oe  <= 1'b0;
            guard  <= '0;
        end else begin
            hd_reg <= hd_nxt;
            tx_oe  <= hd_nxt ? (tx_next != TX_IDLE) : 1'b1;
            if (hd_reg && tx_state == TX_STOP && tx_next == TX_IDLE)
                guard <= {tx_div, 4'hF};
            else if (guard != '0)
                guard <= guard - GW'(1);
        end
    end

    // A new error in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
            err_tx_ovf  <= 1'b0;
        end else begin
            if (par_evt_q)                               err_parity  <= 1'b1;
            else if (err_clr)                            err_parity  <= 1'b0;
            if (frame_evt_q)                             err_frame   <= 1'b1;
            else if (err_clr)                            err_frame   <= 1'b0;
            if (rx_push_q && rx_full && !rx_rd_en)       err_overrun <= 1'b1;
            else if (err_clr)                            err_overrun <= 1'b0;
            if (tx_wr_en && tx_full && !tx_pop)          err_tx_ovf  <= 1'b1;
            else if (err_clr)                            err_tx_ovf  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_fifo_hd.sv
// Directed self-checking bench for uart_fifo_hd: 8E2 frames, clk_div=3 (64 clk/bit, 12 bits/frame).

module tb_uart_fifo_hd;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] clk_div;
    logic        half_duplex;
    logic [7:0]  tx_data;
    logic        tx_wr_en;
    logic        tx_full, tx_empty;
    logic [4:0]  tx_level;
    logic [7:0]  rx_data;
    logic        rx_rd_en;
    logic        rx_full, rx_empty;
    logic [4:0]  rx_level;
    logic        err_parity, err_frame, err_overrun, err_tx_ovf;
    logic        err_clr;
    logic        busy, tx, tx_oe, rx;
    logic        loop, rx_drv;

    int checks = 0;
    int errors = 0;
    int push_at;
    int pa;
    bit found;

    localparam int BIT = 64;
    localparam int FRAME = 12 * BIT;

    always #5 clk = ~clk;
    assign rx = loop ? tx : rx_drv;

    uart_fifo_hd dut (
        .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .half_duplex(half_duplex),
        .tx_data(tx_data), .tx_wr_en(tx_wr_en), .tx_full(tx_full), .tx_empty(tx_empty),
        .tx_level(tx_level), .rx_data(rx_data), .rx_rd_en(rx_rd_en), .rx_full(rx_full),
        .rx_empty(rx_empty), .rx_level(rx_level), .err_parity(err_parity),
        .err_frame(err_frame), .err_overrun(err_overrun), .err_tx_ovf(err_tx_ovf),
        .err_clr(err_clr), .busy(busy), .tx(tx), .tx_oe(tx_oe), .rx(rx)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Index 0 is the start bit, then data LSB first, parity, stop1, stop2.
    function automatic logic [11:0] frame_bits(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        frame_bits = {1'b1, ~bad_stop, (^d) ^ bad_par, d, 1'b0};
    endfunction

    task automatic write_byte(input logic [7:0] d);
        tx_data  = d;
        tx_wr_en = 1'b1;
        step(1);
        tx_wr_en = 1'b0;
    endtask

    task automatic pop_check(input logic [7:0] expected, input string tag);
        check(tag, rx_data, expected);
        rx_rd_en = 1'b1;
        step(1);
        rx_rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                               input int pop_at, output int pushed_at);
        logic [11:0] bits;
        logic [4:0]  lvl0;
        bits      = frame_bits(d, bad_par, bad_stop);
        lvl0      = rx_level;
        pushed_at = -1;
        for (int i = 0; i < FRAME; i++) begin
            rx_drv   = bits[i / BIT];
            rx_rd_en = (i == pop_at);
            step(1);
            if (pushed_at < 0 && rx_level != lvl0) pushed_at = i;
        end
        rx_rd_en = 1'b0;
        rx_drv   = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [11:0] exp_bits;
        rst_n = 1'b0; clk_div = 16'd3; half_duplex = 1'b0; tx_data = '0; tx_wr_en = 1'b0;
        rx_rd_en = 1'b0; err_clr = 1'b0; loop = 1'b0; rx_drv = 1'b1; push_at = -1;
        step(3);
        check("rst_tx", tx, 1'b1);
        check("rst_tx_oe", tx_oe, 1'b0);
        check("rst_levels", {tx_level, rx_level}, 10'd0);
        check("rst_empty", {tx_empty, rx_empty}, 2'b11);
        check("rst_busy", busy, 1'b0);
        check("rst_errs", {err_parity, err_frame, err_overrun, err_tx_ovf}, 4'b0000);
        rst_n = 1'b1;
        step(2);
        check("fd_tx_oe", tx_oe, 1'b1);

        $display("[TB] single frame 0x55");
        write_byte(8'h55);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1);
            if (tx == 1'b0) found = 1'b1;
        end
        check("t1_start_seen", found, 1'b1);
        exp_bits = frame_bits(8'h55, 1'b0, 1'b0);
        step(BIT / 2);
        for (int b = 0; b < 12; b++) begin
            check($sformatf("t1_bit%0d", b), tx, exp_bits[b]);
            if (b < 11) step(BIT);
        end
        step(FRAME - 1 - (11 * BIT + BIT / 2));
        check("t1_busy_last", busy, 1'b1);
        step(1);
        check("t1_busy_done", busy, 1'b0);
        check("t1_tx_idle", tx, 1'b1);

        $display("[TB] full-duplex loopback back-to-back");
        loop = 1'b1;
        tx_wr_en = 1'b1;
        tx_data = 8'hA3; step(1);
        tx_data = 8'h00; step(1);
        tx_data = 8'hFF; step(1);
        tx_wr_en = 1'b0;
        step(3 * FRAME - 2);
        check("t2_busy_last", busy, 1'b1);
        step(1);
        check("t2_busy_done", busy, 1'b0);
        step(20);
        check("t2_rx_level", rx_level, 5'd3);
        check("t2_errs", {err_parity, err_frame, err_overrun, err_tx_ovf}, 4'b0000);
        pop_check(8'hA3, "t2_rx0");
        pop_check(8'h00, "t2_rx1");
        pop_check(8'hFF, "t2_rx2");
        check("t2_rx_empty", rx_empty, 1'b1);

        $display("[TB] half-duplex echo suppression");
        half_duplex = 1'b1;
        step(2);
        check("t3_oe_idle", tx_oe, 1'b0);
        write_byte(8'h12);
        step(1);
        check("t3_oe_rise", tx_oe, 1'b1);
        step(FRAME - 1);
        check("t3_oe_last", tx_oe, 1'b1);
        step(1);
        check("t3_oe_fall", tx_oe, 1'b0);
        step(100);
        check("t3_no_echo", {rx_empty, rx_level}, {1'b1, 5'd0});
        check("t3_errs", {err_parity, err_frame, err_overrun}, 3'b000);
        loop = 1'b0;
        drive_frame(8'h34, 1'b0, 1'b0, -1, pa);
        step(5);
        check("t3_rx_level", rx_level, 5'd1);
        pop_check(8'h34, "t3_rx_data");
        half_duplex = 1'b0;
        step(2);
        check("t3_fd_oe", tx_oe, 1'b1);

        $display("[TB] parity and framing errors");
        drive_frame(8'h01, 1'b1, 1'b0, -1, pa);
        step(5);
        check("t4_par_err", {err_parity, err_frame}, 2'b10);
        check("t4_par_drop", rx_empty, 1'b1);
        pulse_clr();
        check("t4_par_clr", err_parity, 1'b0);
        drive_frame(8'h01, 1'b0, 1'b1, -1, pa);
        step(5);
        check("t4_frame_err", {err_parity, err_frame}, 2'b01);
        check("t4_frame_drop", rx_empty, 1'b1);
        pulse_clr();
        check("t4_frame_clr", err_frame, 1'b0);

        $display("[TB] RX overrun and pop+push on full");
        for (int k = 0; k < 17; k++) begin
            drive_frame(8'h10 + 8'(k), 1'b0, 1'b0, -1, pa);
            if (k == 0) push_at = pa;
        end
        step(5);
        check("t5_push_seen", push_at >= 0, 1'b1);
        check("t5_level", rx_level, 5'd16);
        check("t5_full", rx_full, 1'b1);
        check("t5_overrun", err_overrun, 1'b1);
        check("t5_head", rx_data, 8'h10);
        pulse_clr();
        check("t5_ovr_clr", err_overrun, 1'b0);
        drive_frame(8'hEE, 1'b0, 1'b0, push_at, pa);
        step(2);
        check("t5_popush_level", rx_level, 5'd16);
        check("t5_popush_noovr", err_overrun, 1'b0);
        for (int k = 1; k < 16; k++) pop_check(8'h10 + 8'(k), $sformatf("t5_rd%0d", k));
        pop_check(8'hEE, "t5_rd_last");
        check("t5_empty", rx_empty, 1'b1);
        rx_rd_en = 1'b1; step(1); rx_rd_en = 1'b0;
        check("t5_pop_empty", rx_level, 5'd0);

        $display("[TB] TX overflow and mid-frame reset");
        tx_data = 8'h00;
        tx_wr_en = 1'b1;
        step(18);
        tx_wr_en = 1'b0;
        check("t6_tx_level", tx_level, 5'd16);
        check("t6_tx_full", tx_full, 1'b1);
        check("t6_tx_ovf", err_tx_ovf, 1'b1);
        step(270);
        check("t6_tx_low_bit3", tx, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_tx", tx, 1'b1);
        check("t6_rst_levels", {tx_level, rx_level}, 10'd0);
        check("t6_rst_oe_busy", {tx_oe, busy}, 2'b00);
        check("t6_rst_ovf", err_tx_ovf, 1'b0);
        #2;
        rst_n = 1'b1;
        step(2);
        check("t6_oe_after", tx_oe, 1'b1);

        $display("[TB] start-bit glitch");
        rx_drv = 1'b0;
        step(16);
        rx_drv = 1'b1;
        step(800);
        check("t6_glitch_empty", rx_empty, 1'b1);
        check("t6_glitch_errs", {err_parity, err_frame, err_overrun, err_tx_ovf}, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
